// File: rtl/hsem_lock_ctrl_pkg.sv
// Shared definitions for the HSEM semaphore bank: error bit positions,
// clear-all key, read-data field layout and scan FSM encoding.
`ifndef HSEM_LOCK_CTRL_DEFINES
`define HSEM_LOCK_CTRL_DEFINES
`define AHB_DATA_WIDTH 32
`define SEMERR_WIDTH   8
`define HSEM_CLR_KEY   16'hC1EA
`endif

package hsem_lock_ctrl_pkg;

   localparam int ERR_UNLOCK_NOT_OWNER = 0;
   localparam int ERR_UNLOCK_FREE      = 1;
   localparam int ERR_LOCK_BUSY        = 2;
   localparam int ERR_BAD_INDEX        = 3;
   localparam int ERR_BAD_KEY          = 4;
   localparam int ERR_ACCESS_BUSY      = 5;

   localparam int RDATA_LOCK_BIT = 31;
   localparam int RDATA_CORE_LSB = 8;
   localparam int RDATA_PROC_LSB = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

endpackage

// File: rtl/hsem_cell.sv
// One hardware semaphore: lock bit plus owner core/process IDs, with the
// owner comparison used by lock, unlock and clear-all decisions.
module hsem_cell #(
   parameter int CORE_ID_W = 1,
   parameter int PROC_ID_W = 8
) (
   input  logic                 hclk,
   input  logic                 hreset,
   input  logic [CORE_ID_W-1:0] req_core,
   input  logic [PROC_ID_W-1:0] req_proc,
   input  logic                 wr_lock,
   input  logic                 rd_lock,
   input  logic                 wr_unlock,
   input  logic                 scan_free,
   output logic                 locked,
   output logic [CORE_ID_W-1:0] core_id,
   output logic [PROC_ID_W-1:0] proc_id,
   output logic                 owner_match,
   output logic                 free_evt
);

   assign owner_match = locked && (core_id == req_core) && (proc_id == req_proc);

   // The top only raises one request per cycle; a 1-step lock records PROCID 0.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         locked   <= 1'b0;
         core_id  <= '0;
         proc_id  <= '0;
         free_evt <= 1'b0;
      end else begin
         free_evt <= 1'b0;
         if (wr_lock && !locked) begin
            locked  <= 1'b1;
            core_id <= req_core;
            proc_id <= req_proc;
         end else if (rd_lock && !locked) begin
            locked  <= 1'b1;
            core_id <= req_core;
            proc_id <= '0;
         end else if ((wr_unlock && owner_match) || (scan_free && locked)) begin
            locked   <= 1'b0;
            core_id  <= '0;
            proc_id  <= '0;
            free_evt <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/hsem_lock_ctrl.sv
// Semaphore bank core: decodes AHB accesses onto NUM_SEM cells, runs the
// per-core clear-all scan and produces registered semerr pulses.
module hsem_lock_ctrl
   import hsem_lock_ctrl_pkg::*;
#(
   parameter int NUM_SEM   = 8,
   parameter int SEM_IDX_W = 3,
   parameter int PROC_ID_W = 8,
   parameter int CORE_ID_W = 1
) (
   input  logic                       hclk,
   input  logic                       hreset,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic                       sem_sel,
   input  logic                       clr_sel,
   input  logic [SEM_IDX_W:0]         sem_idx,
   input  logic                       rlock,
   input  logic [CORE_ID_W-1:0]       hmaster_id,
   input  logic [`AHB_DATA_WIDTH-1:0] ihwdata,
   output logic [`AHB_DATA_WIDTH-1:0] sem_rdata,
   output logic [`SEMERR_WIDTH-1:0]   semerr,
   output logic [NUM_SEM-1:0]         sem_free_evt,
   output logic [NUM_SEM-1:0]         lock_stat,
   output logic                       busy
);

   localparam logic [SEM_IDX_W-1:0] LAST_IDX = SEM_IDX_W'(NUM_SEM - 1);

   scan_state_t                state, state_next;
   logic [SEM_IDX_W-1:0]       scan_idx, scan_idx_next;
   logic [CORE_ID_W-1:0]       clr_core, clr_core_next;
   logic [`SEMERR_WIDTH-1:0]   err_next;

   logic [NUM_SEM-1:0]         wr_lock, rd_lock, wr_unlock, scan_free;
   logic [NUM_SEM-1:0]         cell_locked, cell_owner;
   logic [CORE_ID_W-1:0]       cell_core [NUM_SEM];
   logic [PROC_ID_W-1:0]       cell_proc [NUM_SEM];

   logic [SEM_IDX_W-1:0]       idx;
   logic                       idx_oob;
   logic                       unused_wdata;

   assign idx          = sem_idx[SEM_IDX_W-1:0];
   assign idx_oob      = sem_idx[SEM_IDX_W];
   assign busy         = (state == ST_SCAN);
   assign lock_stat    = cell_locked;
   assign unused_wdata = ^ihwdata;

   for (genvar g = 0; g < NUM_SEM; g++) begin : g_cell
      hsem_cell #(
         .CORE_ID_W (CORE_ID_W),
         .PROC_ID_W (PROC_ID_W)
      ) u_cell (
         .hclk        (hclk),
         .hreset      (hreset),
         .req_core    (hmaster_id),
         .req_proc    (ihwdata[PROC_ID_W-1:0]),
         .wr_lock     (wr_lock[g]),
         .rd_lock     (rd_lock[g]),
         .wr_unlock   (wr_unlock[g]),
         .scan_free   (scan_free[g]),
         .locked      (cell_locked[g]),
         .core_id     (cell_core[g]),
         .proc_id     (cell_proc[g]),
         .owner_match (cell_owner[g]),
         .free_evt    (sem_free_evt[g])
      );
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state    <= ST_IDLE;
         scan_idx <= '0;
         clr_core <= '0;
         semerr   <= '0;
      end else begin
         state    <= state_next;
         scan_idx <= scan_idx_next;
         clr_core <= clr_core_next;
         semerr   <= err_next;
      end
   end

   // Access decode, error encoding and scan sequencing; every access raises at most one error bit.
   always_comb begin
      wr_lock       = '0;
      rd_lock       = '0;
      wr_unlock     = '0;
      scan_free     = '0;
      err_next      = '0;
      sem_rdata     = '0;
      state_next    = state;
      scan_idx_next = scan_idx;
      clr_core_next = clr_core;
      case (state)
         ST_IDLE: begin
            if ((wr_en || rd_en) && sem_sel) begin
               if (idx_oob) begin
                  err_next[ERR_BAD_INDEX] = 1'b1;
               end else begin
                  if (rd_en) begin
                     sem_rdata[RDATA_LOCK_BIT]               = cell_locked[idx];
                     sem_rdata[RDATA_CORE_LSB +: CORE_ID_W]  = cell_core[idx];
                     sem_rdata[RDATA_PROC_LSB +: PROC_ID_W]  = cell_proc[idx];
                  end
                  if (wr_en) begin
                     if (ihwdata[RDATA_LOCK_BIT]) begin
                        if (!cell_locked[idx])
                           wr_lock[idx] = 1'b1;
                        else if (!cell_owner[idx])
                           err_next[ERR_LOCK_BUSY] = 1'b1;
                     end else begin
                        if (!cell_locked[idx])
                           err_next[ERR_UNLOCK_FREE] = 1'b1;
                        else if (cell_owner[idx])
                           wr_unlock[idx] = 1'b1;
                        else
                           err_next[ERR_UNLOCK_NOT_OWNER] = 1'b1;
                     end
                  end else if (rlock && !cell_locked[idx]) begin
                     rd_lock[idx] = 1'b1;
                  end
               end
            end else if (wr_en && clr_sel) begin
               if (ihwdata[15:0] == `HSEM_CLR_KEY) begin
                  state_next    = ST_SCAN;
                  scan_idx_next = '0;
                  clr_core_next = hmaster_id;
               end else begin
                  err_next[ERR_BAD_KEY] = 1'b1;
               end
            end
         end
         ST_SCAN: begin
            if ((wr_en || rd_en) && (sem_sel || clr_sel))
               err_next[ERR_ACCESS_BUSY] = 1'b1;
            if (cell_locked[scan_idx] && (cell_core[scan_idx] == clr_core))
               scan_free[scan_idx] = 1'b1;
            if (scan_idx == LAST_IDX) begin
               state_next    = ST_IDLE;
               scan_idx_next = '0;
            end else begin
               scan_idx_next = scan_idx + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hsem_lock_ctrl.sv
// Directed self-checking bench for hsem_lock_ctrl: lock/unlock paths, error
// pulses, clear-all scan timing and reset during a scan.
module tb_hsem_lock_ctrl;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic        sem_sel = 1'b0;
   logic        clr_sel = 1'b0;
   logic [3:0]  sem_idx = '0;
   logic        rlock = 1'b0;
   logic [0:0]  hmaster_id = '0;
   logic [31:0] ihwdata = '0;
   logic [31:0] sem_rdata;
   logic [7:0]  semerr;
   logic [7:0]  sem_free_evt;
   logic [7:0]  lock_stat;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int busyCycles;
   logic [7:0] evtSeen;
   logic [7:0] expEvt;
   logic       busySeen;

   hsem_lock_ctrl #(
      .NUM_SEM   (8),
      .SEM_IDX_W (3),
      .PROC_ID_W (8),
      .CORE_ID_W (1)
   ) dut (
      .hclk         (hclk),
      .hreset       (hreset),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .sem_sel      (sem_sel),
      .clr_sel      (clr_sel),
      .sem_idx      (sem_idx),
      .rlock        (rlock),
      .hmaster_id   (hmaster_id),
      .ihwdata      (ihwdata),
      .sem_rdata    (sem_rdata),
      .semerr       (semerr),
      .sem_free_evt (sem_free_evt),
      .lock_stat    (lock_stat),
      .busy         (busy)
   );

   always #5 hclk = ~hclk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one access mid-cycle so combinational read data can be sampled before the edge.
   task automatic applyStimulus(input logic wr, input logic rd, input logic sem, input logic clr,
                                input logic [3:0] idx, input logic rl, input logic core,
                                input logic [31:0] data);
      @(negedge hclk);
      wr_en = wr; rd_en = rd; sem_sel = sem; clr_sel = clr;
      sem_idx = idx; rlock = rl; hmaster_id = core; ihwdata = data;
      #1;
   endtask

   task automatic finishCycle();
      @(posedge hclk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; sem_sel = 1'b0; clr_sel = 1'b0;
      sem_idx = '0; rlock = 1'b0; hmaster_id = '0; ihwdata = '0;
   endtask

   task automatic idleCycle();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      repeat (3) @(negedge hclk);
      hreset = 1'b0;
      #1;
      checkOutput("rst_lock_stat", {24'h0, lock_stat}, 32'h0);
      checkOutput("rst_busy", {31'h0, busy}, 32'h0);
      checkOutput("rst_semerr", {24'h0, semerr}, 32'h0);
      checkOutput("rst_free_evt", {24'h0, sem_free_evt}, 32'h0);
      checkOutput("rst_rdata", sem_rdata, 32'h0);

      // 2-step lock of idx2 by core0/proc5, then status read and a competing lock
      applyStimulus(1, 0, 1, 0, 4'd2, 0, 1'b0, 32'h8000_0005);
      finishCycle();
      checkOutput("lock2_stat", {24'h0, lock_stat}, 32'h04);
      checkOutput("lock2_err", {24'h0, semerr}, 32'h00);
      applyStimulus(0, 1, 1, 0, 4'd2, 0, 1'b0, 32'h0);
      checkOutput("read2_rdata", sem_rdata, 32'h8000_0005);
      finishCycle();
      applyStimulus(1, 0, 1, 0, 4'd2, 0, 1'b1, 32'h8000_0005);
      finishCycle();
      checkOutput("lock_busy_err", {24'h0, semerr}, 32'h04);
      checkOutput("lock_busy_stat", {24'h0, lock_stat}, 32'h04);
      idleCycle();
      checkOutput("lock_busy_pulse_end", {24'h0, semerr}, 32'h00);

      // 1-step lock of idx3 by core1
      applyStimulus(0, 1, 1, 0, 4'd3, 1, 1'b1, 32'h0);
      checkOutput("rlr3_rdata_pre", sem_rdata, 32'h0);
      finishCycle();
      checkOutput("rlr3_stat", {24'h0, lock_stat}, 32'h0C);
      applyStimulus(0, 1, 1, 0, 4'd3, 0, 1'b0, 32'h0);
      checkOutput("read3_rdata", sem_rdata, 32'h8000_0100);
      finishCycle();
      applyStimulus(0, 1, 1, 0, 4'd3, 1, 1'b1, 32'h0);
      checkOutput("rlr3_again_rdata", sem_rdata, 32'h8000_0100);
      finishCycle();
      checkOutput("rlr3_again_err", {24'h0, semerr}, 32'h00);
      checkOutput("rlr3_again_stat", {24'h0, lock_stat}, 32'h0C);

      // Unlock paths on idx2
      applyStimulus(1, 0, 1, 0, 4'd2, 0, 1'b1, 32'h0000_0005);
      finishCycle();
      checkOutput("unlock_not_owner_err", {24'h0, semerr}, 32'h01);
      checkOutput("unlock_not_owner_stat", {24'h0, lock_stat}, 32'h0C);
      applyStimulus(1, 0, 1, 0, 4'd2, 0, 1'b0, 32'h0000_0005);
      finishCycle();
      checkOutput("unlock2_evt", {24'h0, sem_free_evt}, 32'h04);
      checkOutput("unlock2_stat", {24'h0, lock_stat}, 32'h08);
      checkOutput("unlock2_err", {24'h0, semerr}, 32'h00);
      applyStimulus(1, 0, 1, 0, 4'd2, 0, 1'b0, 32'h0000_0005);
      finishCycle();
      checkOutput("unlock2_evt_end", {24'h0, sem_free_evt}, 32'h00);
      checkOutput("unlock_free_err", {24'h0, semerr}, 32'h02);

      // Out-of-range index
      applyStimulus(0, 1, 1, 0, 4'b1000, 1, 1'b0, 32'h0);
      checkOutput("oob_rdata", sem_rdata, 32'h0);
      finishCycle();
      checkOutput("oob_err", {24'h0, semerr}, 32'h08);
      checkOutput("oob_stat", {24'h0, lock_stat}, 32'h08);

      // Free idx3 (core1, PROCID 0)
      applyStimulus(1, 0, 1, 0, 4'd3, 0, 1'b1, 32'h0);
      finishCycle();
      checkOutput("unlock3_evt", {24'h0, sem_free_evt}, 32'h08);
      checkOutput("unlock3_stat", {24'h0, lock_stat}, 32'h00);

      // Clear-all by core0 with idx 0,4,7 owned by core0 and idx1 by core1
      applyStimulus(1, 0, 1, 0, 4'd0, 0, 1'b0, 32'h8000_0001);
      finishCycle();
      applyStimulus(1, 0, 1, 0, 4'd4, 0, 1'b0, 32'h8000_0001);
      finishCycle();
      applyStimulus(1, 0, 1, 0, 4'd7, 0, 1'b0, 32'h8000_0001);
      finishCycle();
      applyStimulus(1, 0, 1, 0, 4'd1, 0, 1'b1, 32'h8000_0002);
      finishCycle();
      checkOutput("pre_clear_stat", {24'h0, lock_stat}, 32'h93);
      applyStimulus(1, 0, 0, 1, 4'd0, 0, 1'b0, 32'h0000_C1EA);
      finishCycle();
      checkOutput("clear_busy_start", {31'h0, busy}, 32'h1);
      busyCycles = 1;
      evtSeen = '0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 3) begin
            applyStimulus(1, 0, 1, 0, 4'd5, 0, 1'b0, 32'h8000_0009);
            finishCycle();
         end else begin
            idleCycle();
         end
         expEvt = (k == 1) ? 8'h01 : (k == 5) ? 8'h10 : (k == 8) ? 8'h80 : 8'h00;
         checkOutput($sformatf("scan_evt_%0d", k), {24'h0, sem_free_evt}, {24'h0, expEvt});
         checkOutput($sformatf("scan_err_%0d", k), {24'h0, semerr}, (k == 3) ? 32'h20 : 32'h00);
         evtSeen = evtSeen | sem_free_evt;
         if (busy) busyCycles++;
      end
      checkOutput("clear_busy_cycles", busyCycles, 32'd8);
      checkOutput("clear_evt_set", {24'h0, evtSeen}, 32'h91);
      checkOutput("clear_stat", {24'h0, lock_stat}, 32'h02);
      checkOutput("clear_busy_end", {31'h0, busy}, 32'h0);

      // Bad clear key
      applyStimulus(1, 0, 0, 1, 4'd0, 0, 1'b0, 32'h0000_0000);
      finishCycle();
      checkOutput("bad_key_err", {24'h0, semerr}, 32'h10);
      checkOutput("bad_key_busy", {31'h0, busy}, 32'h0);
      idleCycle();
      checkOutput("bad_key_busy_later", {31'h0, busy}, 32'h0);

      // Reset during a core1 clear-all scan
      applyStimulus(1, 0, 1, 0, 4'd6, 0, 1'b1, 32'h8000_0003);
      finishCycle();
      checkOutput("pre_rst_scan_stat", {24'h0, lock_stat}, 32'h42);
      applyStimulus(1, 0, 0, 1, 4'd0, 0, 1'b1, 32'h0000_C1EA);
      finishCycle();
      checkOutput("rst_scan_busy", {31'h0, busy}, 32'h1);
      idleCycle();
      idleCycle();
      checkOutput("rst_scan_evt1", {24'h0, sem_free_evt}, 32'h02);
      checkOutput("rst_scan_stat1", {24'h0, lock_stat}, 32'h40);
      #2;
      hreset = 1'b1;
      #1;
      checkOutput("mid_rst_busy", {31'h0, busy}, 32'h0);
      checkOutput("mid_rst_stat", {24'h0, lock_stat}, 32'h00);
      checkOutput("mid_rst_evt", {24'h0, sem_free_evt}, 32'h00);
      repeat (2) idleCycle();
      @(negedge hclk);
      hreset = 1'b0;
      evtSeen = '0;
      busySeen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         idleCycle();
         evtSeen = evtSeen | sem_free_evt;
         busySeen = busySeen | busy;
      end
      checkOutput("post_rst_evt", {24'h0, evtSeen}, 32'h00);
      checkOutput("post_rst_busy", {31'h0, busySeen}, 32'h0);
      checkOutput("post_rst_stat", {24'h0, lock_stat}, 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hsem_lock_ctrl.md
Name: hsem_lock_ctrl

Overview:
- Semaphore bank core of the HSEM block; sits directly upstream of hsem_ine and produces the semerr error pulses it latches.
- Holds NUM_SEM hardware semaphores with owner core/process IDs; supports 2-step (write) lock, 1-step (read) lock, owner-checked unlock and a sequenced per-core clear-all.
- Emits per-semaphore release events used by the interrupt logic for task-switch notification.

Parameters:
- NUM_SEM, 8, number of semaphores; power of 2, range 2..32.
- SEM_IDX_W, 3, log2(NUM_SEM).
- PROC_ID_W, 8, process ID width.
- CORE_ID_W, 1, core ID width (core 0 / core 1).

Ports:
- hclk  in  1  clock.
- hreset  in  1  asynchronous active-high reset.
- wr_en  in  1  qualified AHB write strobe, data phase.
- rd_en  in  1  qualified AHB read strobe, data phase.
- sem_sel  in  1  access targets the semaphore array.
- clr_sel  in  1  access targets the clear-all register.
- sem_idx  in  SEM_IDX_W+1  semaphore index; MSB set means out of range.
- rlock  in  1  read is a 1-step lock read (RLR), else plain status read.
- hmaster_id  in  CORE_ID_W  requesting core.
- ihwdata  in  `AHB_DATA_WIDTH  write data: [31] LOCK, [15:0] clear key, [PROC_ID_W-1:0] PROCID.
- sem_rdata  out  `AHB_DATA_WIDTH  {LOCK, 15'b0, COREID zero-extended to 8, PROCID zero-extended to 8}.
- semerr  out  `SEMERR_WIDTH  registered one-cycle error pulses.
- sem_free_evt  out  NUM_SEM  one-cycle pulse per semaphore released.
- lock_stat  out  NUM_SEM  current LOCK bit of every semaphore.
- busy  out  1  clear-all scan in progress.

Behaviour:
- Reset: all semaphores free, owner fields 0; semerr, sem_free_evt, lock_stat 0; busy 0; FSM in IDLE.
- State per semaphore: lock bit, core ID, proc ID.
- 2-step lock (wr_en, sem_sel, LOCK=1):
  - Free: take lock, store hmaster_id and PROCID.
  - Locked by same core and PROCID: no change, no error.
  - Otherwise: no change, semerr[2] LOCK_BUSY.
- 1-step lock (rd_en, sem_sel, rlock):
  - sem_rdata returns the pre-access state combinationally in the same data phase.
  - If free: lock with core = hmaster_id, PROCID = 0; success visible on the following status read.
  - Locked: no change, no error.
- Unlock (wr_en, sem_sel, LOCK=0):
  - Owner core and PROCID match: free the semaphore, clear owner fields, pulse sem_free_evt[i] next cycle.
  - Semaphore already free: semerr[1] UNLOCK_FREE.
  - Mismatch: semerr[0] UNLOCK_NOT_OWNER.
- Plain status read: no side effect.
- Out-of-range sem_idx on any access: no state change, sem_rdata 0, semerr[3] BAD_INDEX.
- Clear-all (wr_en, clr_sel):
  - Key must equal `HSEM_CLR_KEY (16'hC1EA); a bad key sets semerr[4] BAD_KEY and causes no FSM entry.
  - Valid key: capture hmaster_id into clr_core, enter SCAN with idx counter 0, busy=1.
  - SCAN: one semaphore per cycle; if locked and core == clr_core, free it and pulse sem_free_evt[idx].
  - After idx NUM_SEM-1: return to IDLE, busy=0. Total busy time is exactly NUM_SEM cycles.
- Any sem_sel or clr_sel access while busy: ignored, semerr[5] ACCESS_BUSY, sem_rdata 0.
- Latency: all state, semerr and sem_free_evt updates are registered (+1 cycle after the strobe); lock_stat reflects registered state.
- Simultaneous wr_en and rd_en: write has priority; the read still returns pre-write data.
- Multiple semerr bits may not be set by a single access; unused semerr bits are tied 0.
- Reset asserted mid-scan: immediate return to IDLE, all semaphores free, no sem_free_evt pulses.

Decomposition:
- Shared defines file holds: `SEMERR_WIDTH, semerr bit indices (UNLOCK_NOT_OWNER=0 .. ACCESS_BUSY=5), `HSEM_CLR_KEY, rdata field positions, FSM encodings (IDLE=1'b0, SCAN=1'b1).
- One sub-module, hsem_cell, holds one semaphore's state and lock/unlock compare logic, generated NUM_SEM times.
- Scan FSM, index decode and error encoding stay in the top module.

Test Plan:
- Core0 writes idx2 LOCK=1 PROCID=8'h05 -> lock_stat[2]=1; status read returns 32'h8000_0005; core1 same write -> semerr[2] pulse, state unchanged.
- Core1 RLR on free idx3 -> rdata 0 that cycle; next status read 32'h8000_0100; second RLR -> no error, state unchanged.
- Core1 unlocks idx2 (owned by core0/5) -> semerr[0]; core0 unlocks PROCID 5 -> sem_free_evt[2] one-cycle pulse; repeat unlock -> semerr[1].
- Access with sem_idx=4'b1000 -> rdata 0, semerr[3], no state change.
- Core0 owns idx 0,4,7 and core1 owns idx 1; core0 clear-all with key 16'hC1EA -> busy high exactly 8 cycles, pulses on 0,4,7 only, idx1 remains locked; a write during the scan -> semerr[5].
- Clear with key 16'h0000 -> semerr[4], busy stays 0; hreset asserted at scan cycle 3 -> all free, busy 0, no further events.
